// File: rtl/maze_pkg.sv
// Shared types and the coordinate stepping helper for the maze solver.
package maze_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MARK,
    CHECK,
    BACK,
    DONE,
    FAIL
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] c;
  } coord_t;

  // sign=1 steps against d; opposite codes are bitwise complements
  function automatic coord_t step(coord_t p, dir_t d, logic sign);
    coord_t n;
    dir_t   e;
    n = p;
    e = dir_t'(d ^ {2{sign}});
    case (e)
      UP:    n.r = p.r - COORD_W'(1);
      DOWN:  n.r = p.r + COORD_W'(1);
      RIGHT: n.c = p.c + COORD_W'(1);
      LEFT:  n.c = p.c - COORD_W'(1);
      default: n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/maze_solver_stack.sv
// Move stack: LIFO of 2-bit direction codes with a registered random-read port.
module solver_stack
  import maze_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] push_dir,
  output logic [1:0] top,
  output logic [8:0] count,
  output logic       full,
  output logic       empty,
  input  logic [7:0] rd_addr,
  output logic [1:0] rd_dir
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem [DEPTH];
  logic [8:0]    cnt_q, cnt_d;
  logic [1:0]    rd_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = AW'(wr_idx - AW'(1));
  assign full    = (cnt_q == 9'(DEPTH));
  assign empty   = (cnt_q == 9'd0);
  assign top     = mem[top_idx];
  assign count   = cnt_q;
  assign rd_dir  = rd_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = 9'd0;
    else if (push && !full)
      cnt_d = cnt_q + 9'd1;
    else if (pop && !empty)
      cnt_d = cnt_q - 9'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 9'd0;
      rd_q  <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= mem[rd_addr[AW-1:0]];
    end
  end

  // storage needs no reset; only the pointer defines contents
  always_ff @(posedge clock) begin
    if (push && !full && !clear)
      mem[wr_idx] <= push_dir;
  end

endmodule

// File: rtl/maze_solver.sv
// Depth-first maze solver: marks cells, pushes moves, backtracks on dead ends.
module maze_solver
  import maze_pkg::*;
#(
  parameter int START_ROW   = 0,
  parameter int START_COL   = 0,
  parameter int GOAL_ROW    = 15,
  parameter int GOAL_COL    = 15,
  parameter int STACK_DEPTH = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] dirs,
  output logic [3:0] row,
  output logic [3:0] column,
  output logic       write,
  output logic       init,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len,
  input  logic [7:0] rd_addr,
  output logic [1:0] rd_dir
);

  localparam coord_t START = '{
    r: COORD_W'(START_ROW),
    c: COORD_W'(START_COL)
  };
  localparam coord_t GOAL = '{
    r: COORD_W'(GOAL_ROW),
    c: COORD_W'(GOAL_COL)
  };

  state_t state_q, state_d;
  coord_t pos_q, pos_d;
  logic   write_q, init_q;
  logic   busy_q, done_q, fail_q;

  logic       clr, psh, pop;
  dir_t       pick;
  logic [1:0] top;
  logic       full, empty;

  solver_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clock   (clock),
    .reset   (reset),
    .clear   (clr),
    .push    (psh),
    .pop     (pop),
    .push_dir(pick),
    .top     (top),
    .count   (path_len),
    .full    (full),
    .empty   (empty),
    .rd_addr (rd_addr),
    .rd_dir  (rd_dir)
  );

  always_comb begin
    pick = UP;
    priority case (1'b1)
      dirs[3]: pick = DOWN;
      dirs[1]: pick = RIGHT;
      dirs[2]: pick = LEFT;
      default: pick = UP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    clr     = 1'b0;
    psh     = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d = INIT;
          pos_d   = START;
          clr     = 1'b1;
        end
      end
      INIT: state_d = MARK;
      MARK: state_d = CHECK;
      CHECK: begin
        if (pos_q == GOAL) begin
          state_d = DONE;
        end else if (dirs != 4'd0) begin
          if (full) begin
            state_d = FAIL;
          end else begin
            psh     = 1'b1;
            pos_d   = step(pos_q, pick, 1'b0);
            state_d = MARK;
          end
        end else if (!empty) begin
          state_d = BACK;
        end else begin
          state_d = FAIL;
        end
      end
      BACK: begin
        pop     = 1'b1;
        pos_d   = step(pos_q, dir_t'(top), 1'b1);
        state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= START;
      write_q <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      write_q <= (state_d == MARK);
      init_q  <= (state_d == INIT);
      busy_q  <= (state_d inside {INIT, MARK, CHECK, BACK});
      done_q  <= (state_d == DONE);
      fail_q  <= (state_d == FAIL);
    end
  end

  assign row    = pos_q.r;
  assign column = pos_q.c;
  assign write  = write_q;
  assign init   = init_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign fail   = fail_q;

endmodule

// File: doc/maze_solver.md
MAZE_SOLVER -- requirements
Module: maze_solver

Interface
REQ-001 SHALL have parameter START_ROW, default 0: starting row.
REQ-002 SHALL have parameter START_COL, default 0: starting column.
REQ-003 SHALL have parameter GOAL_ROW, default 15: target row.
REQ-004 SHALL have parameter GOAL_COL, default 15: target column.
REQ-005 SHALL have parameter STACK_DEPTH, default 256: maximum path length in moves.
REQ-006 SHALL have port clock  input  1  clock; all state updates on the rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  one-cycle pulse that begins a solve.
REQ-009 SHALL have port dirs  input  4  open-neighbour flags from maze memory: [0]=up, [1]=right, [2]=left, [3]=down; combinational from row/column.
REQ-010 SHALL have port row  output  4  current cell row, driven to maze memory.
REQ-011 SHALL have port column  output  4  current cell column, driven to maze memory.
REQ-012 SHALL have port write  output  1  marks the current cell visited in maze memory.
REQ-013 SHALL have port init  output  1  reloads the maze image in maze memory.
REQ-014 SHALL have port busy / done / fail  output  1 each  solve in progress / goal reached / no path.
REQ-015 SHALL have port path_len  output  9  number of moves on the stack.
REQ-016 SHALL have port rd_addr  input  8  path readout index, 0 = first move.
REQ-017 SHALL have port rd_dir  output  2  move stored at rd_addr, registered; valid 1 cycle after rd_addr.

Function
REQ-018 SHALL implement FSM states IDLE, INIT, MARK, CHECK, BACK, DONE, FAIL.
REQ-019 IDLE/DONE/FAIL: start=1 -> INIT; clear stack; row/column <= START_ROW/START_COL.
REQ-020 INIT: init=1 for exactly one cycle -> MARK.
REQ-021 MARK: write=1 for exactly one cycle at current row/column -> CHECK.
REQ-022 CHECK at goal cell -> DONE; do not sample dirs.
REQ-023 CHECK with dirs != 0: pick by fixed priority down(3) > right(1) > left(2) > up(0); push the direction code; step row/column one cell -> MARK.
REQ-024 CHECK with dirs == 0 and stack non-empty -> BACK.
REQ-025 CHECK with dirs == 0 and stack empty -> FAIL.
REQ-026 BACK: pop the top entry; step row/column opposite to it -> CHECK. Visited cells are never re-marked.
REQ-027 Push with stack full (path_len == STACK_DEPTH) -> FAIL with no push and no move.
REQ-028 start while busy SHALL be ignored.
REQ-029 busy=1 in INIT, MARK, CHECK and BACK; done=1 only in DONE; fail=1 only in FAIL.
REQ-030 write and init SHALL never be asserted in the same cycle.
REQ-031 path_len SHALL equal the stack occupancy; in DONE it is the solution length.
REQ-032 rd_dir SHALL return the stack entry at rd_addr in any state; entries at or beyond path_len are don't-care.
REQ-033 Coordinate steps SHALL be 4-bit unsigned. A move toward an edge cannot occur because memory reports edges closed. No wrap logic is required.

Reset
REQ-034 Reset SHALL give: state IDLE; row=START_ROW; column=START_COL; write=0; init=0; busy=0; done=0; fail=0; path_len=0; rd_dir=0.
REQ-035 Reset mid-solve SHALL abandon the solve immediately; stack contents need not be cleared, only the pointer.

Structure
REQ-036 Package maze_pkg SHALL hold the dir_t enum (UP=0, RIGHT=1, LEFT=2, DOWN=3), the FSM state enum, and the coordinate width constant (4).
REQ-037 Sub-module solver_stack SHALL be a LIFO of STACK_DEPTH x 2 bits with push, pop, top, count, full and empty, plus an independent registered random-read port (rd_addr/rd_dir).
REQ-038 All row/column stepping SHALL use one shared function in maze_pkg, step(dir, sign).

Verification
REQ-039 Open 16x16 maze (all zeros) in a behavioural memory model, start pulse -> done=1, path_len=30, rd_dir[0..14]=3, rd_dir[15..29]=1, fail=0.
REQ-040 Start cell boxed in (dirs=0 at 0,0) -> fail=1, path_len=0, exactly one write pulse, one init pulse.
REQ-041 Maze where DOWN from (0,0) reaches a dead end at (3,0) -> BACK pops 3 entries back to (0,0), then RIGHT is taken, done=1, no cell written twice.
REQ-042 Assert reset during MARK after 10 moves -> next cycle busy=0, write=0, path_len=0, row=column=0; a new start solves normally.
REQ-043 start pulsed while busy -> no change to state, path_len or init; solve completes with the same result as an undisturbed run.
REQ-044 STACK_DEPTH=4 with goal 5 moves away on an open corridor -> fail=1, path_len=4.
